button_decoder: RTL

BUTTON_DECODER -- requirements
Module: button_decoder

---
 rtl/button_decoder_pkg.sv | 24 ++
 rtl/button_fsm.sv | 142 ++++++++++++++
 rtl/button_decoder.sv | 98 +++++++++
 3 files changed

// File: rtl/button_decoder_pkg.sv
// Shared definitions for the two-button decoder: per-button FSM state
// encoding, default tick constants and the counter-width helper.
package button_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_DEB_PRESS   = 2'd1,
    ST_HELD        = 2'd2,
    ST_DEB_RELEASE = 2'd3
  } btn_state_t;

  // Tick period is 2**DEF_CLK_DIV_BITS CLK cycles (about 24.4 kHz at 100 MHz).
  localparam int DEF_CLK_DIV_BITS   = 12;
  // About 20 ms of stable samples before a level change is accepted.
  localparam int DEF_DEBOUNCE_TICKS = 488;
  // About 1 s of holding before a long press is reported.
  localparam int DEF_LONG_TICKS     = 24414;

  // Width of a counter that must hold the larger of the two tick limits.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/button_fsm.sv
// Per-button debounce / press / release / long-press state machine.
// All counting and transitions happen on tick cycles only; event outputs
// are registered one-CLK pulses. Long-press detection is present only when
// BUTTON_DECODER_LONG_EN is defined; otherwise long_pulse is tied low.
module button_fsm
  import button_decoder_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int LONG_TICKS     = DEF_LONG_TICKS
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       tick,
  input  logic       pressed,
  output logic       level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [1:0] dbg_state
);

  localparam int CW = cnt_width(DEBOUNCE_TICKS, LONG_TICKS);

  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
`ifdef BUTTON_DECODER_LONG_EN
  logic [CW-1:0] hold_q, hold_d;
  logic          long_flag_q, long_flag_d;
  logic          long_q, long_d;
`endif

  // State, counters and registered event pulses.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
`ifdef BUTTON_DECODER_LONG_EN
      hold_q      <= '0;
      long_flag_q <= 1'b0;
      long_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
`ifdef BUTTON_DECODER_LONG_EN
      hold_q      <= hold_d;
      long_flag_q <= long_flag_d;
      long_q      <= long_d;
`endif
    end
  end

  // Next-state logic; pulses default low so they last exactly one CLK.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
`ifdef BUTTON_DECODER_LONG_EN
    hold_d      = hold_q;
    long_flag_d = long_flag_q;
    long_d      = 1'b0;
`endif
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (pressed) begin
            state_d = ST_DEB_PRESS;
            cnt_d   = CW'(1);
          end
        end
        ST_DEB_PRESS: begin
          if (!pressed) begin
            state_d = ST_IDLE;
          end else if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
            state_d     = ST_HELD;
            cnt_d       = cnt_q + 1'b1;
            level_d     = 1'b1;
            press_d     = 1'b1;
`ifdef BUTTON_DECODER_LONG_EN
            hold_d      = '0;
            long_flag_d = 1'b0;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_HELD: begin
          if (!pressed) begin
            state_d = ST_DEB_RELEASE;
            cnt_d   = CW'(1);
          end else begin
`ifdef BUTTON_DECODER_LONG_EN
            // Saturate at LONG_TICKS; long_flag keeps LONG to one pulse per press.
            if (hold_q != CW'(LONG_TICKS)) begin
              hold_d = hold_q + 1'b1;
              if ((hold_q == CW'(LONG_TICKS - 1)) && !long_flag_q) begin
                long_d      = 1'b1;
                long_flag_d = 1'b1;
              end
            end
`endif
          end
        end
        ST_DEB_RELEASE: begin
          if (pressed) begin
            state_d = ST_HELD;
          end else if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
            state_d   = ST_IDLE;
            cnt_d     = cnt_q + 1'b1;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign dbg_state     = state_q;
`ifdef BUTTON_DECODER_LONG_EN
  assign long_pulse    = long_q;
`else
  assign long_pulse    = 1'b0;
`endif

endmodule

// File: rtl/button_decoder.sv
// Two-button decoder: pad synchronizers, shared tick divider, one
// button_fsm per button and the COMBO detector. Long-press outputs are
// active only when BUTTON_DECODER_LONG_EN is defined.
// DBG_STATE exposes {but2_state, but1_state} for observation.
module button_decoder
  import button_decoder_pkg::*;
#(
  parameter int CLK_DIV_BITS   = DEF_CLK_DIV_BITS,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int LONG_TICKS     = DEF_LONG_TICKS
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BUT1,
  input  logic       BUT2,
  output logic       BUT1_LEVEL,
  output logic       BUT2_LEVEL,
  output logic       BUT1_PRESS,
  output logic       BUT2_PRESS,
  output logic       BUT1_RELEASE,
  output logic       BUT2_RELEASE,
  output logic       BUT1_LONG,
  output logic       BUT2_LONG,
  output logic       COMBO,
  output logic [3:0] DBG_STATE
);

  logic [1:0]              sync1_q, sync2_q;
  logic [CLK_DIV_BITS-1:0] div_q;
  logic                    tick;
  logic                    both_prev_q;
  logic                    combo_q;
  logic [1:0]              st1, st2;

  // Two-flop synchronizers; reset to the released (high) pad level.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= {BUT2, BUT1};
      sync2_q <= sync1_q;
    end
  end

  // Free-running divider; the tick enable marks its all-ones to zero wrap.
  always_ff @(posedge CLK) begin
    if (!RST_N) div_q <= '0;
    else        div_q <= div_q + 1'b1;
  end

  assign tick = &div_q;

  button_fsm #(
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
    .LONG_TICKS     (LONG_TICKS)
  ) u_but1 (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .tick          (tick),
    .pressed       (~sync2_q[0]),
    .level         (BUT1_LEVEL),
    .press_pulse   (BUT1_PRESS),
    .release_pulse (BUT1_RELEASE),
    .long_pulse    (BUT1_LONG),
    .dbg_state     (st1)
  );

  button_fsm #(
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
    .LONG_TICKS     (LONG_TICKS)
  ) u_but2 (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .tick          (tick),
    .pressed       (~sync2_q[1]),
    .level         (BUT2_LEVEL),
    .press_pulse   (BUT2_PRESS),
    .release_pulse (BUT2_RELEASE),
    .long_pulse    (BUT2_LONG),
    .dbg_state     (st2)
  );

  // COMBO: rising edge of "both levels pressed", registered one CLK later.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      both_prev_q <= 1'b0;
      combo_q     <= 1'b0;
    end else begin
      both_prev_q <= BUT1_LEVEL & BUT2_LEVEL;
      combo_q     <= BUT1_LEVEL & BUT2_LEVEL & ~both_prev_q;
    end
  end

  assign COMBO     = combo_q;
  assign DBG_STATE = {st2, st1};

endmodule
